serial_alu_sequencer: RTL and testbench
=======================================

Name: serial_alu_sequencer

Overview:
- Upstream driver for the team's 1-bit ALU slice (ports a, b, CarryIn, ALUOp, Result, CarryOut).
- Accepts a WIDTH-bit operation and streams operands into the slice one bit per clock, LSB first.
- Registers the slice's CarryOut and feeds it back as the next bit's CarryIn, forming a bit-serial ripple adder.
- Collects Result bits into a WIDTH-bit word and reports result, carry_out, zero with a done pulse.
- The slice sits outside this block; the sequencer only connects to it through the alu_* ports.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2); also the number of RUN cycles.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; accepted only on a cycle with ready=1
- op_in  input  4  ALUOp: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR
- a_in  input  WIDTH  operand A
- b_in  input  WIDTH  operand B
- ready  output  1  high in IDLE only
- done  output  1  one-cycle pulse when result is valid
- result  output  WIDTH  final word; held until the next accepted start
- carry_out  output  1  final MSB carry for ADD/SUB; 0 for all other ops
- zero  output  1  result==0, updated together with result
- alu_a  output  1  to slice a
- alu_b  output  1  to slice b
- alu_carry_in  output  1  to slice CarryIn
- alu_op  output  4  to slice ALUOp (latched op)
- alu_result  input  1  from slice Result
- alu_carry_out  input  1  from slice CarryOut

Behaviour:
- States: IDLE -> RUN -> DONE -> IDLE.
- Reset (any state, including mid-RUN):
  - state=IDLE; ready=1.
  - done=0, result=0, carry_out=0, zero=0.
  - alu_a=0, alu_b=0, alu_carry_in=0, alu_op=0000.
  - Bit counter, shift registers and carry register cleared.
- IDLE:
  - start=1 at an edge latches a_in, b_in and op_in.
  - Carry register loads op_in[2] (Bnegate), so SUB gets carry-in 1 at bit 0.
  - Counter=0; state moves to RUN.
- RUN, cycle k (k=0..WIDTH-1):
  - alu_a=A[k], alu_b=B[k], alu_carry_in=carry register, alu_op=latched op; all driven from registers.
  - At each edge, alu_result shifts into the collect register at the MSB (right shift) and alu_carry_out loads the carry register.
  - The slice is a combinational path from the alu_* outputs back to alu_result/alu_carry_out, closed within one cycle.
- Last RUN edge (k=WIDTH-1):
  - result gets the collected word; zero is updated.
  - carry_out = alu_carry_out if op is 0010 or 0110, else 0.
  - State moves to DONE.
- DONE: done=1 for exactly one cycle, ready=0, then state returns to IDLE.
- Latency: start accepted at edge T; RUN occupies cycles T+1..T+WIDTH; done=1 in cycle T+WIDTH+1; ready=1 again in cycle T+WIDTH+2.
- start while ready=0 (RUN or DONE) is ignored and not queued.
- Inputs a_in, b_in, op_in may change freely after acceptance; only latched copies are used.
- Outside RUN: alu_a, alu_b and alu_carry_in are 0; alu_op holds the last latched op.
- Unlisted op codes:
  - Accepted and passed to the slice unchanged; carry-in at bit 0 is still op[2].
  - carry_out=0; result is whatever the slice produces.
- Carry wrap: ADD overflow discards bit WIDTH into carry_out. SUB carry_out=1 means no borrow (a>=b unsigned).

Decomposition:
- Shared package alu_pkg:
  - ALUOp localparams ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_NOR.
  - State encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Reused by the slice and its testbenches.
- No sub-module: one FSM, a counter, two operand shift registers, a collect shift register and a carry flop. The 1-bit slice is instantiated beside this block by the parent.

Test Plan (WIDTH=8; bench wires the team's 1-bit slice to the alu_* ports):
- ADD 0x5A+0x3C, start at edge T -> result=0x96, carry_out=0, zero=0, done high only in cycle T+9; ready=0 from T+1 to T+9.
- ADD 0xFF+0x01 -> result=0x00, carry_out=1, zero=1; alu_carry_in=1 on RUN cycles 1..7.
- SUB 0x10-0x01 -> result=0x0F, carry_out=1. Then SUB 0x01-0x02 -> result=0xFF, carry_out=0, with alu_carry_in=1 on RUN cycle 0.
- a=0xF0, b=0x3C: AND -> 0x30, OR -> 0xFC, NOR -> 0x03; carry_out=0 each time; alu_op equals the latched code throughout RUN.
- start re-asserted with new operands during RUN and DONE -> ignored, first result unchanged. Second start issued when ready=1 -> processed normally.
- reset asserted at RUN cycle 4 -> next cycle ready=1, done=0, result=0, alu_a=alu_b=alu_carry_in=0. A fresh ADD 0x01+0x01 then yields 0x02.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUOp codes and the bit-serial sequencer's state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package alu_pkg;

  // ALUOp layout seen by the 1-bit slice: [3]=Ainvert, [2]=Bnegate, [1:0]=function select.
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seqState_t;

  // Only ADD and SUB report a meaningful carry out of the MSB.
  function automatic logic isArith(input logic [3:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/serial_alu_sequencer.sv
// Bit-serial driver for an external 1-bit ALU slice: streams A/B LSB first and collects Result bits.
// Latency: start accepted at edge T, RUN in cycles T+1..T+WIDTH, done pulse in cycle T+WIDTH+1.
// Backpressure: ready is high only in IDLE; start seen while busy is dropped, never queued.
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   start, op_in, a_in, b_in    operation request (taken when ready=1)
//   ready, done                 idle indicator, one-cycle completion pulse
//   result, carry_out, zero     final word, MSB carry (ADD/SUB only), result==0
//   alu_a, alu_b, alu_carry_in, alu_op   drive the slice
//   alu_result, alu_carry_out           returned by the slice in the same cycle
module serial_alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_carry_in,
  output logic [3:0]       alu_op,
  input  logic             alu_result,
  input  logic             alu_carry_out
);

  localparam int CntW = $clog2(WIDTH);

  seqState_t        state, nextState;
  logic [CntW-1:0]  bitCnt;
  logic [WIDTH-1:0] aShift, bShift;
  logic [WIDTH-2:0] collect;      // bits 0..WIDTH-2; the MSB arrives on the last edge
  logic [WIDTH-2:0] collectNext;
  logic             carryReg;
  logic [3:0]       opReg;
  logic             lastBit;

  assign lastBit = (bitCnt == CntW'(WIDTH - 1));
  assign alu_op  = opReg;

  // Result bits enter at the MSB and drift right, so bit 0 lands at position 0.
  if (WIDTH > 2) begin : gCollectWide
    assign collectNext = {alu_result, collect[WIDTH-2:1]};
  end else begin : gCollectNarrow
    assign collectNext = alu_result;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bitCnt    <= '0;
      aShift    <= '0;
      bShift    <= '0;
      collect   <= '0;
      carryReg  <= 1'b0;
      opReg     <= 4'b0000;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          if (start) begin
            aShift   <= a_in;
            bShift   <= b_in;
            opReg    <= op_in;
            // Bnegate doubles as the bit-0 carry-in, giving two's-complement subtract.
            carryReg <= op_in[2];
            bitCnt   <= '0;
          end
        end
        RUN: begin
          aShift   <= aShift >> 1;
          bShift   <= bShift >> 1;
          collect  <= collectNext;
          carryReg <= alu_carry_out;
          bitCnt   <= bitCnt + CntW'(1);
          if (lastBit) begin
            result    <= {alu_result, collect};
            zero      <= ({alu_result, collect} == '0);
            carry_out <= isArith(opReg) & alu_carry_out;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nextState    = state;
    ready        = 1'b0;
    done         = 1'b0;
    alu_a        = 1'b0;
    alu_b        = 1'b0;
    alu_carry_in = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) nextState = RUN;
      end
      RUN: begin
        alu_a        = aShift[0];
        alu_b        = bShift[0];
        alu_carry_in = carryReg;
        if (lastBit) nextState = DONE;
      end
      DONE: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Bench for serial_alu_sequencer with a behavioural 1-bit slice closing the alu_* loop.
// Latency: expects done exactly WIDTH+1 cycles after the accepting edge.
// Backpressure: drives start only when ready, and injects ignored starts while busy.
module tb_serial_alu_sequencer;
  import alu_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] res;
    logic         cy;
    logic         zr;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         start;
  logic [3:0]   op_in;
  logic [W-1:0] a_in, b_in;
  logic         ready, done;
  logic [W-1:0] result;
  logic         carry_out, zero;
  logic         alu_a, alu_b, alu_carry_in;
  logic [3:0]   alu_op;
  logic         alu_result, alu_carry_out;

  int checks   = 0;
  int failures = 0;
  exp_t expQ[$];
  logic [3:0] opsTab [5] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_NOR};

  serial_alu_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op_in(op_in),
    .a_in(a_in), .b_in(b_in), .ready(ready), .done(done),
    .result(result), .carry_out(carry_out), .zero(zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_carry_in(alu_carry_in), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry_out(alu_carry_out)
  );

  // 1-bit slice: Ainvert/Bnegate, then AND/OR/ADD selected by ALUOp[1:0].
  always_comb begin
    logic aa, bb;
    aa = alu_a ^ alu_op[3];
    bb = alu_b ^ alu_op[2];
    case (alu_op[1:0])
      2'b00:   alu_result = aa & bb;
      2'b01:   alu_result = aa | bb;
      2'b10:   alu_result = aa ^ bb ^ alu_carry_in;
      default: alu_result = 1'b0;
    endcase
    alu_carry_out = (aa & bb) | (aa & alu_carry_in) | (bb & alu_carry_in);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Word-level reference: plain arithmetic on whole operands.
  function automatic exp_t refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [3:0] op);
    exp_t e;
    logic [W:0] s;
    case (op)
      ALU_AND: s = {1'b0, a & b};
      ALU_OR:  s = {1'b0, a | b};
      ALU_NOR: s = {1'b0, ~(a | b)};
      ALU_ADD: s = {1'b0, a} + {1'b0, b};
      ALU_SUB: s = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      default: s = '0;
    endcase
    e.res = s[W-1:0];
    e.cy  = s[W];
    e.zr  = (s[W-1:0] == '0);
    return e;
  endfunction

  // Carry into bit k of an ADD/SUB, from the sum of the low k bits.
  function automatic logic carryInto(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [3:0] op, input int k);
    logic [W-1:0] bb;
    int unsigned m, s;
    bb = (op == ALU_SUB) ? ~b : b;
    m  = (32'd1 << k) - 32'd1;
    s  = (32'(a) & m) + (32'(bb) & m) + ((op == ALU_SUB) ? 32'd1 : 32'd0);
    return s[k];
  endfunction

  // Scoreboard monitor: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (expQ.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        check("result", 32'(result), 32'(e.res));
        check("carry_out", 32'(carry_out), 32'(e.cy));
        check("zero", 32'(zero), 32'(e.zr));
      end
    end
  end

  // Waits for ready, presents one request for a single cycle; returns in RUN cycle 0.
  task automatic startOp(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] op, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(ready), 32'd1);
    a_in  = a;
    b_in  = b;
    op_in = op;
    start = 1'b1;
    if (push) expQ.push_back(refModel(a, b, op));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Full operation with per-cycle checks of the slice drive and handshake timing.
  task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] op, input bit noise);
    startOp(a, b, op, 1'b1);
    for (int k = 0; k < W; k++) begin
      check("alu_a", 32'(alu_a), 32'(a[k]));
      check("alu_b", 32'(alu_b), 32'(b[k]));
      check("alu_op", 32'(alu_op), 32'(op));
      check("ready_run", 32'(ready), 32'd0);
      check("done_run", 32'(done), 32'd0);
      if (op == ALU_ADD || op == ALU_SUB)
        check("alu_carry_in", 32'(alu_carry_in), 32'(carryInto(a, b, op, k)));
      if (noise) begin
        start = 1'b1;
        a_in  = 8'($urandom);
        b_in  = 8'($urandom);
        op_in = opsTab[$urandom_range(4, 0)];
      end
      @(negedge clk);
    end
    check("done_pulse", 32'(done), 32'd1);
    check("ready_done", 32'(ready), 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("done_after", 32'(done), 32'd0);
    check("ready_after", 32'(ready), 32'd1);
  endtask

  task automatic checkResetState();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_carry_out", 32'(carry_out), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_alu_carry_in", 32'(alu_carry_in), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op_in = 4'b0000;
    a_in  = '0;
    b_in  = '0;
    repeat (3) @(negedge clk);
    checkResetState();
    reset = 1'b0;

    // Directed cases.
    runOp(8'h5A, 8'h3C, ALU_ADD, 1'b0);
    runOp(8'hFF, 8'h01, ALU_ADD, 1'b0);
    runOp(8'h10, 8'h01, ALU_SUB, 1'b0);
    runOp(8'h01, 8'h02, ALU_SUB, 1'b0);
    runOp(8'hF0, 8'h3C, ALU_AND, 1'b0);
    runOp(8'hF0, 8'h3C, ALU_OR, 1'b0);
    runOp(8'hF0, 8'h3C, ALU_NOR, 1'b0);

    // Requests while busy must be dropped; the next proper one runs normally.
    runOp(8'h33, 8'h44, ALU_ADD, 1'b1);
    runOp(8'h80, 8'h80, ALU_ADD, 1'b0);

    // Reset in the middle of RUN cycle 4 abandons the operation.
    runOp(8'hC3, 8'h15, ALU_OR, 1'b0);
    startOp(8'h5A, 8'h3C, ALU_ADD, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkResetState();
    reset = 1'b0;
    runOp(8'h01, 8'h01, ALU_ADD, 1'b0);

    // Randomized operations against the word-level model.
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] a, b;
      a = 8'($urandom);
      b = ($urandom_range(3, 0) == 0) ? a : 8'($urandom);
      runOp(a, b, opsTab[$urandom_range(4, 0)], ($urandom_range(3, 0) == 0));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
